// File: rtl/tinydcim_tile_if.sv
// Command and result channels of the tinydcim tile. The master drives commands
// and consumes results; the slave is the tile.
interface tinydcim_tile_if #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ACT_BITS = 4
);
    localparam int AW    = $clog2(ROWS);
    localparam int ACC_W = ACT_BITS + $clog2(ROWS + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [AW-1:0]         cmd_addr;
    logic [COLS-1:0]       cmd_data;
    logic                  signed_mode;
    logic                  res_valid;
    logic                  res_ready;
    logic [COLS*ACC_W-1:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, signed_mode, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, signed_mode, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/tinydcim_tile.sv
// Bit-serial digital compute-in-memory tile: 1-bit weights times ACT_BITS-bit
// activations, one activation bit-plane per cycle, one accumulator per column.
module tinydcim_col #(
    parameter int ROWS  = 8,
    parameter int ACC_W = 8,
    parameter int BW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic             neg_i,
    input  logic [BW-1:0]    b_i,
    input  logic [ROWS-1:0]  w_i,
    input  logic [ROWS-1:0]  a_i,
    output logic [ACC_W-1:0] acc_o
);
    localparam int PW = $clog2(ROWS + 1);

    logic [PW-1:0]    pop;
    logic [ACC_W-1:0] part;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        pop = '0;
        for (int r = 0; r < ROWS; r++) pop = pop + PW'(w_i[r] & a_i[r]);
        part = ACC_W'(pop) << b_i;
        acc_d = acc_q;
        if (clr_i)       acc_d = '0;
        else if (step_i) acc_d = neg_i ? acc_q - part : acc_q + part;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

module tinydcim_tile #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ACT_BITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    tinydcim_tile_if.slave bus,
    output logic           busy
);
    localparam int AW    = $clog2(ROWS);
    localparam int ACC_W = ACT_BITS + $clog2(ROWS + 1);
    localparam int BW    = $clog2(ACT_BITS);
    localparam logic [BW-1:0] B_LAST = BW'(ACT_BITS - 1);

    localparam logic [1:0] OP_LOADW = 2'b00, OP_LOADA = 2'b01,
                           OP_COMP  = 2'b10, OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;
    state_t state_q, state_d;

    logic [ROWS-1:0][COLS-1:0]     w_q;
    logic [ROWS-1:0][ACT_BITS-1:0] a_q;
    logic [BW-1:0]                 b_q;
    logic                          sm_q;
    logic                          accept, start, step, neg;
    logic [ROWS-1:0]               abit;
    logic [COLS-1:0][ACC_W-1:0]    acc;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign start  = accept && (bus.cmd_op == OP_COMP);
    assign step   = ena && (state_q == COMP);
    assign neg    = sm_q && (b_q == B_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMP;
            COMP:    if (ena && b_q == B_LAST) state_d = DONE;
            DONE:    if (ena && bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = ena && (state_q == IDLE);
        bus.res_valid = (state_q == DONE);
        busy          = (state_q == COMP) || (state_q == DONE);
    end

    // Weight/activation storage and the bit-plane counter; accept already implies ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            sm_q <= 1'b0;
        end else if (accept) begin
            case (bus.cmd_op)
                OP_LOADW: w_q[bus.cmd_addr] <= bus.cmd_data;
                OP_LOADA: a_q[bus.cmd_addr] <= bus.cmd_data[ACT_BITS-1:0];
                OP_CLEAR: begin
                    w_q <= '0;
                    a_q <= '0;
                end
                default: begin
                    b_q  <= '0;
                    sm_q <= bus.signed_mode;
                end
            endcase
        end else if (step) begin
            b_q <= (b_q == B_LAST) ? '0 : b_q + 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) abit[r] = a_q[r][b_q];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0] wcol;
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign wcol[r] = w_q[r][c];
        end
        tinydcim_col #(.ROWS(ROWS), .ACC_W(ACC_W), .BW(BW)) u_col (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (start),
            .step_i(step),
            .neg_i (neg),
            .b_i   (b_q),
            .w_i   (wcol),
            .a_i   (abit),
            .acc_o (acc[c])
        );
    end

    assign bus.res_data = acc;
endmodule

// File: tb/tb_tinydcim_tile.sv
// Directed bench for tinydcim_tile at ROWS=8, COLS=8, ACT_BITS=4 (ACC_W=8).
module tb_tinydcim_tile;
    localparam logic [1:0] LOADW = 2'b00, LOADA = 2'b01, COMPUTE = 2'b10, CLEAR = 2'b11;

    logic clk = 1'b0;
    logic rst_n, ena, busy;
    int   vecs = 0;
    int   errs = 0;

    tinydcim_tile_if #(.ROWS(8), .COLS(8), .ACT_BITS(4)) bus ();

    tinydcim_tile #(.ROWS(8), .COLS(8), .ACT_BITS(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic cmd(input logic [1:0] op, input int addr, input logic [7:0] data, input logic sm);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_addr    = 3'(addr);
        bus.cmd_data    = data;
        bus.signed_mode = sm;
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b0;
        bus.signed_mode = 1'b0;
    endtask

    task automatic load_full(input logic [7:0] wv, input logic [7:0] av);
        for (int r = 0; r < 8; r++) begin
            cmd(LOADW, r, wv, 1'b0);
            cmd(LOADA, r, av, 1'b0);
        end
    endtask

    // Returns cycles from the accepting edge to res_valid, or 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (bus.res_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0;
        bus.cmd_data = '0; bus.signed_mode = 1'b0; bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        vecs++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL reset_ready_ena0 got %b want 0", bus.cmd_ready); end
        ena = 1'b1; #1;
        vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
        vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", bus.res_valid); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (bus.res_data !== 64'h0) begin errs++; $display("FAIL reset_data got %h want 0", bus.res_data); end
    endtask

    task automatic test_unsigned();
        int lat;
        load_full(8'hFF, 8'h0F);
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        vecs++; if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL uns_busy got busy=%b rdy=%b want 1/0", busy, bus.cmd_ready); end
        wait_done(lat);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL uns_latency got %0d want 4", lat); end
        vecs++; if (bus.res_data !== {8{8'h78}}) begin errs++; $display("FAIL uns_data got %h want %h", bus.res_data, {8{8'h78}}); end
        consume();
        vecs++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL uns_release got v=%b busy=%b want 0/0", bus.res_valid, busy); end
        vecs++; if (bus.res_data !== {8{8'h78}}) begin errs++; $display("FAIL uns_retain got %h want %h", bus.res_data, {8{8'h78}}); end
    endtask

    task automatic test_signed();
        int lat;
        cmd(COMPUTE, 0, 8'h00, 1'b1);
        wait_done(lat);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL sgn_latency got %0d want 4", lat); end
        vecs++; if (bus.res_data !== {8{8'hF8}}) begin errs++; $display("FAIL sgn_data got %h want %h", bus.res_data, {8{8'hF8}}); end
        consume();
        for (int r = 0; r < 8; r++) cmd(LOADA, r, 8'h08, 1'b0);
        cmd(COMPUTE, 0, 8'h00, 1'b1);
        wait_done(lat);
        vecs++; if (bus.res_data !== {8{8'hC0}}) begin errs++; $display("FAIL sgn_min got %h want %h", bus.res_data, {8{8'hC0}}); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        for (int r = 0; r < 8; r++) cmd(LOADA, r, 8'h0F, 1'b0);
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        wait_done(lat);
        bus.cmd_valid = 1'b1; bus.cmd_op = CLEAR;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vecs++;
            if (bus.res_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.res_data !== {8{8'h78}}) begin
                errs++;
                $display("FAIL bp_hold cyc %0d got v=%b rdy=%b d=%h want 1/0/%h", i, bus.res_valid, bus.cmd_ready, bus.res_data, {8{8'h78}});
            end
        end
        bus.cmd_valid = 1'b0;
        consume();
        // The CLEAR offered during DONE must have been dropped.
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        wait_done(lat);
        vecs++; if (bus.res_data !== {8{8'h78}}) begin errs++; $display("FAIL bp_repeat got %h want %h", bus.res_data, {8{8'h78}}); end
        consume();
    endtask

    task automatic test_ena();
        int lat = 0;
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 1) ena = 1'b0;
            if (n == 4) ena = 1'b1;
            if (bus.res_valid) begin lat = n; break; end
        end
        vecs++; if (lat !== 7) begin errs++; $display("FAIL ena_latency got %0d want 7", lat); end
        vecs++; if (bus.res_data !== {8{8'h78}}) begin errs++; $display("FAIL ena_data got %h want %h", bus.res_data, {8{8'h78}}); end
        ena = 1'b0; bus.res_ready = 1'b1;
        @(posedge clk); #1;
        vecs++; if (bus.res_valid !== 1'b1) begin errs++; $display("FAIL ena_freeze_done got %b want 1", bus.res_valid); end
        ena = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL ena_resume got %b want 0", bus.res_valid); end
    endtask

    task automatic test_col_map();
        int lat;
        logic [63:0] exp;
        for (int r = 0; r < 8; r++) begin
            cmd(LOADW, r, 8'(1 << r), 1'b0);
            cmd(LOADA, r, 8'(r), 1'b0);
        end
        for (int c = 0; c < 8; c++) exp[c*8 +: 8] = 8'(c);
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        wait_done(lat);
        vecs++; if (bus.res_data !== exp) begin errs++; $display("FAIL colmap got %h want %h", bus.res_data, exp); end
        consume();
        cmd(CLEAR, 0, 8'h00, 1'b0);
        vecs++; if (bus.res_data !== exp) begin errs++; $display("FAIL clear_keeps_acc got %h want %h", bus.res_data, exp); end
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        wait_done(lat);
        vecs++; if (bus.res_data !== 64'h0) begin errs++; $display("FAIL clear_zero got %h want 0", bus.res_data); end
        consume();
    endtask

    task automatic test_reset_midop();
        int lat;
        load_full(8'hFF, 8'h0F);
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vecs++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_busy got busy=%b v=%b want 0/0", busy, bus.res_valid); end
        vecs++; if (bus.res_data !== 64'h0) begin errs++; $display("FAIL rst_mid_data got %h want 0", bus.res_data); end
        @(posedge clk); #1 rst_n = 1'b1;
        cmd(COMPUTE, 0, 8'h00, 1'b0);
        wait_done(lat);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL rst_mid_latency got %0d want 4", lat); end
        vecs++; if (bus.res_data !== 64'h0) begin errs++; $display("FAIL rst_mid_result got %h want 0", bus.res_data); end
        consume();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_ena();
        test_col_map();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/tinydcim_tile.md
TINYDCIM_TILE -- requirements
Module: tinydcim_tile

Interface
REQ-001 SHALL have parameters: ROWS, default 8, weight/activation rows (>=2, power of 2); COLS, default 8, output columns (>=1); ACT_BITS, default 4, activation precision (>=2).
REQ-002 SHALL derive localparams AW = clog2(ROWS) and ACC_W = ACT_BITS + clog2(ROWS+1).
REQ-003 SHALL run on one clock, clk, input, 1 bit, with all state updated on its rising edge.
REQ-004 SHALL have rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have ena, input, 1 bit, design enable; low freezes all state.
REQ-006 SHALL have cmd_valid, input, 1 bit, command offered.
REQ-007 SHALL have cmd_ready, output, 1 bit, command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have cmd_op, input, 2 bits: 00 = LOADW, 01 = LOADA, 10 = COMPUTE, 11 = CLEAR.
REQ-009 SHALL have cmd_addr, input, AW bits, row index for LOADW/LOADA.
REQ-010 SHALL have cmd_data, input, COLS bits: the weight row for LOADW; bits [ACT_BITS-1:0] are the activation for LOADA.
REQ-011 SHALL have signed_mode, input, 1 bit, sampled on COMPUTE accept; 1 = activations are two's complement.
REQ-012 SHALL have res_valid, output, 1 bit, results available.
REQ-013 SHALL have res_ready, input, 1 bit, results consumed when res_valid and res_ready are both high.
REQ-014 SHALL have res_data, output, COLS*ACC_W bits, with column c at bits [c*ACC_W +: ACC_W].
REQ-015 SHALL have busy, output, 1 bit, high in COMP or DONE.

Function
REQ-016 SHALL store a ROWS x COLS array of 1-bit weights W[r][c] and ROWS ACT_BITS-bit activations A[r], all in flops.
REQ-017 SHALL implement an FSM with states IDLE, COMP and DONE.
REQ-018 SHALL drive cmd_ready = ena and (state == IDLE), combinationally.
REQ-019 SHALL, on LOADW accept, write W[cmd_addr][*] = cmd_data and stay in IDLE.
REQ-020 SHALL, on LOADA accept, write A[cmd_addr] = cmd_data[ACT_BITS-1:0] and stay in IDLE.
REQ-021 SHALL, on CLEAR accept, zero all W and A in one cycle, leave accumulators untouched, and stay in IDLE.
REQ-022 SHALL, on COMPUTE accept, zero all COLS accumulators, latch signed_mode, set bit counter b = 0, and enter COMP.
REQ-023 SHALL, on each enabled COMP edge, update acc[c] += (popcount over r of (A[r][b] AND W[r][c])) << b, then set b = b + 1.
REQ-024 SHALL, when signed mode is latched and b = ACT_BITS-1, subtract the shifted partial instead of adding it.
REQ-025 SHALL perform all accumulation in ACC_W-bit two's complement; overflow cannot occur by construction.
REQ-026 SHALL, on the edge processing b = ACT_BITS-1, enter DONE, so res_valid is first high exactly ACT_BITS cycles after the accepting edge.
REQ-027 SHALL drive res_valid = (state == DONE) and res_data directly from the accumulators.
REQ-028 SHALL hold res_data stable in DONE until res_ready.
REQ-029 SHALL, when res_valid and res_ready are high on the same edge, return to IDLE with accumulators retained, so res_data still shows the last result.
REQ-030 SHALL ignore cmd_valid in COMP and DONE; no command is queued.
REQ-031 SHALL, while ena = 0, make no state, counter, accumulator, W or A change and accept nothing; operation resumes where it stopped when ena returns high.
REQ-032 SHALL treat W and A as unaffected by COMPUTE, so repeated COMPUTE gives identical results.

Reset
REQ-033 SHALL, while rst_n = 0 (asynchronous), force state IDLE, b = 0, all W, A and accumulators to 0, and latched signed_mode to 0.
REQ-034 SHALL, after reset, drive res_valid = 0, busy = 0, res_data = 0, and cmd_ready = ena.
REQ-035 SHALL, if reset is asserted in COMP or DONE, abort the operation with the REQ-033 values; no partial result survives.

Verification (ROWS=8, COLS=8, ACT_BITS=4, ACC_W=8)
REQ-036 SHALL check reset: reset, then ena = 1 -> cmd_ready = 1, res_valid = 0, busy = 0, res_data = 0.
REQ-037 SHALL check unsigned full-scale: LOADW all rows 0xFF, LOADA all rows 0xF, COMPUTE with signed_mode = 0 -> res_valid high 4 cycles after accept, every column = 0x78 (120).
REQ-038 SHALL check signed mode: same loads, signed_mode = 1 -> every column = 0xF8 (-8); then A[r] = 0x8 for all r -> every column = 0xC0 (-64).
REQ-039 SHALL check column mapping: W[r] = 1<<r and A[r] = r for r = 0..7 -> column c = c; CLEAR then COMPUTE -> all columns 0.
REQ-040 SHALL check backpressure and ena: hold res_ready = 0 for 10 cycles in DONE -> res_valid and res_data stable and cmd_ready = 0; ena = 0 for 3 cycles mid-COMP -> result unchanged, latency grows by 3.
REQ-041 SHALL check reset mid-operation: assert rst_n = 0 two cycles into COMP -> immediately busy = 0, res_data = 0, and a subsequent COMPUTE without reloading gives all columns 0.
